// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//
// Shared types for the programmable mod_counter family used across the FIR
// datapath (tap-index sequencing, circular buffer pointers, rate strobes).
//
// Contents:
//   cnt_mode_t   - terminal behaviour selector driven on the 'mode' port
//   cnt_state_t  - RUN/DONE state of the one-shot controller
//   mode_wraps() - true for modes that wrap at terminal (wrap and reserved)
// ---------------------------------------------------------------------------
package counter_pkg;

    // Terminal behaviour. The reserved encoding is kept in the enum so that
    // every 2-bit value on the port maps onto a named constant.
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_t;

    // RUN: counting allowed. DONE: a one-shot has completed and the counter
    // is frozen until cleared, loaded or switched out of one-shot mode.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cnt_state_t;

    // The reserved mode is treated exactly like wrap so that an unexpected
    // mode value still yields a well-defined, free-running counter.
    function automatic logic mode_wraps(input cnt_mode_t m);
        return (m == CNT_WRAP) || (m == CNT_RSVD);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//
// Runtime-programmable up/down counter with a programmable terminal value and
// three terminal behaviours (wrap, saturate, one-shot). Successor to the
// plain free-running enable counter.
//
// Parameters:
//   WIDTH     - counter width in bits; count covers 0..2^WIDTH-1
//   RESET_VAL - count value restored by rst (must fit in WIDTH bits)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear (count=0, ovf=0, back to RUN)
//   en        in   count enable
//   load      in   synchronous load of load_val (overrides en)
//   load_val  in   value used by load
//   dir       in   1 = count up towards limit, 0 = count down towards 0
//   mode      in   0 wrap, 1 saturate, 2 one-shot, 3 reserved (as wrap)
//   limit     in   upper end of the count range 0..limit
//   ovf_clr   in   clears the sticky overflow flag
//   count     out  registered count value
//   tc        out  registered one-cycle pulse after a step taken at terminal
//   ovf       out  sticky flag, set on every wrap event
//   running   out  low while a completed one-shot is parked in DONE
// ---------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             running
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    cnt_state_t       state_q;
    cnt_state_t       state_d;

    cnt_mode_t        mode_s;
    logic             at_term;
    logic             wrap_evt;

    assign mode_s = cnt_mode_t'(mode);

    // Up-count reaches terminal at or above limit, so a count left above a
    // freshly lowered limit is treated as terminal rather than running on
    // past it. Down-count terminates only at zero.
    assign at_term = dir ? (count_q >= limit) : (count_q == '0);

    // Next-count and next-state selection. Priority is clr, then load, then
    // the enabled step. A parked one-shot ignores en; it only leaves DONE via
    // clr, load, or seeing a mode other than one-shot on this edge.
    // A down-count that starts above limit is first clamped to limit; that
    // clamp is deliberately not a terminal event, so it produces no tc.
    always_comb begin
        count_d  = count_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        wrap_evt = 1'b0;
        if (clr) begin
            count_d = '0;
            state_d = ST_RUN;
        end else if (load) begin
            count_d = load_val;
            state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
            if (mode_s != CNT_ONESHOT) begin
                state_d = ST_RUN;
            end
        end else if (en) begin
            if (at_term) begin
                tc_d = 1'b1;
                if (mode_wraps(mode_s)) begin
                    count_d  = dir ? '0 : limit;
                    wrap_evt = 1'b1;
                end else begin
                    count_d = dir ? limit : '0;
                    if (mode_s == CNT_ONESHOT) begin
                        state_d = ST_DONE;
                    end
                end
            end else if (dir) begin
                count_d = count_q + ONE;
            end else if (count_q > limit) begin
                count_d = limit;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    // Sticky overflow: clr dominates everything, a wrap in the same cycle as
    // ovf_clr keeps the flag set so no wrap event can be silently lost.
    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (wrap_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // All state, including the registered tc pulse and the RUN/DONE
    // controller, lives in one register bank with an asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_COUNT;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_counter
//
// Directed walk through the main counter behaviours followed by a randomized
// phase, all compared against an integer reference model of the counter.
// ---------------------------------------------------------------------------
module tb_mod_counter;

    localparam int W    = 4;
    localparam int RVAL = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] loadVal = '0;
    logic         dir = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] limit = '0;
    logic         ovfClr = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;
    logic         running;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers
    int mCount = RVAL;
    bit mTc = 1'b0;
    bit mOvf = 1'b0;
    bit mRun = 1'b1;

    mod_counter #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .en(en),
        .load(load),
        .load_val(loadVal),
        .dir(dir),
        .mode(mode),
        .limit(limit),
        .ovf_clr(ovfClr),
        .count(count),
        .tc(tc),
        .ovf(ovf),
        .running(running)
    );

    always #5 clk = ~clk;

    // Behavioural model of one clock edge, written from the counter's rules
    task automatic modelEdge();
        int lim;
        bit atTerm;
        bit wrapped;
        lim = int'(limit);
        wrapped = 1'b0;
        mTc = 1'b0;
        if (clr) begin
            mCount = 0;
            mOvf = 1'b0;
            mRun = 1'b1;
        end else begin
            if (load) begin
                mCount = int'(loadVal);
                mRun = 1'b1;
            end else if (!mRun) begin
                if (mode != 2'd2) mRun = 1'b1;
            end else if (en) begin
                atTerm = dir ? (mCount >= lim) : (mCount == 0);
                if (atTerm) begin
                    mTc = 1'b1;
                    if (mode == 2'd1 || mode == 2'd2) begin
                        mCount = dir ? lim : 0;
                        if (mode == 2'd2) mRun = 1'b0;
                    end else begin
                        mCount = dir ? 0 : lim;
                        wrapped = 1'b1;
                    end
                end else if (dir) begin
                    mCount = (mCount + 1) % 16;
                end else if (mCount > lim) begin
                    mCount = lim;
                end else begin
                    mCount = mCount - 1;
                end
            end
            if (ovfClr) mOvf = 1'b0;
            if (wrapped) mOvf = 1'b1;
        end
    endtask

    task automatic modelReset();
        mCount = RVAL;
        mTc = 1'b0;
        mOvf = 1'b0;
        mRun = 1'b1;
    endtask

    task automatic checkOutput(input string tag);
        logic [W-1:0] expCount;
        expCount = W'(mCount);
        checks++;
        assert (count === expCount) else begin
            errors++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, expCount);
        end
        checks++;
        assert (tc === mTc) else begin
            errors++;
            $error("[TB] FAIL %s tc: got %b expected %b", tag, tc, mTc);
        end
        checks++;
        assert (ovf === mOvf) else begin
            errors++;
            $error("[TB] FAIL %s ovf: got %b expected %b", tag, ovf, mOvf);
        end
        checks++;
        assert (running === mRun) else begin
            errors++;
            $error("[TB] FAIL %s running: got %b expected %b", tag, running, mRun);
        end
    endtask

    // Spot check of count against a hand-derived value
    task automatic checkCount(input string tag, input logic [W-1:0] want);
        checks++;
        assert (count === want) else begin
            errors++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, want);
        end
    endtask

    task automatic checkFlag(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare
    task automatic applyStimulus(input string tag, input bit c, input bit ld,
                                 input bit e, input bit d, input bit oc,
                                 input logic [1:0] m, input logic [W-1:0] lv,
                                 input logic [W-1:0] lim);
        clr = c;
        load = ld;
        en = e;
        dir = d;
        ovfClr = oc;
        mode = m;
        loadVal = lv;
        limit = lim;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("reset");
        checkCount("reset_val", 4'd7);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: wrap up-count, limit 5
        applyStimulus("t1_clr", 1, 0, 0, 1, 0, 2'd0, 4'd0, 4'd5);
        for (int i = 0; i < 13; i++) begin
            applyStimulus("t1_wrap", 0, 0, 1, 1, 0, 2'd0, 4'd0, 4'd5);
            if (i == 5) checkFlag("t1_tc_after_wrap", tc, 1'b1);
        end
        checkCount("t1_end", 4'd1);
        checkFlag("t1_ovf_set", ovf, 1'b1);
        applyStimulus("t1_ovfclr", 0, 0, 0, 1, 1, 2'd0, 4'd0, 4'd5);
        checkFlag("t1_ovf_cleared", ovf, 1'b0);

        // 2: saturating down-count from 3
        applyStimulus("t2_load", 0, 1, 0, 0, 0, 2'd1, 4'd3, 4'd5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("t2_sat", 0, 0, 1, 0, 0, 2'd1, 4'd3, 4'd5);
        end
        checkCount("t2_end", 4'd0);
        checkFlag("t2_tc", tc, 1'b1);
        checkFlag("t2_ovf", ovf, 1'b0);

        // 3: one-shot up to limit 2
        applyStimulus("t3_clr", 1, 0, 0, 1, 0, 2'd2, 4'd0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t3_run", 0, 0, 1, 1, 0, 2'd2, 4'd0, 4'd2);
        end
        checkFlag("t3_running_low", running, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t3_done", 0, 0, 1, 1, 0, 2'd2, 4'd0, 4'd2);
        end
        checkCount("t3_hold", 4'd2);
        checkFlag("t3_tc_low", tc, 1'b0);
        applyStimulus("t3_reload", 0, 1, 1, 1, 0, 2'd2, 4'd0, 4'd2);
        checkFlag("t3_running_back", running, 1'b1);
        applyStimulus("t3_resume", 0, 0, 1, 1, 0, 2'd2, 4'd0, 4'd2);
        checkCount("t3_resume_cnt", 4'd1);

        // 4: count above a lowered limit
        applyStimulus("t4_load", 0, 1, 0, 1, 0, 2'd0, 4'd9, 4'd4);
        applyStimulus("t4_up", 0, 0, 1, 1, 0, 2'd0, 4'd9, 4'd4);
        checkCount("t4_up_wrap", 4'd0);
        checkFlag("t4_up_tc", tc, 1'b1);
        applyStimulus("t4_load2", 0, 1, 0, 0, 0, 2'd0, 4'd9, 4'd4);
        applyStimulus("t4_down", 0, 0, 1, 0, 0, 2'd0, 4'd9, 4'd4);
        checkCount("t4_clamp", 4'd4);
        checkFlag("t4_clamp_no_tc", tc, 1'b0);

        // 5: priority of clr over load over en
        applyStimulus("t5_all", 1, 1, 1, 1, 0, 2'd0, 4'd6, 4'd9);
        checkCount("t5_clr_wins", 4'd0);
        checkFlag("t5_ovf", ovf, 1'b0);
        applyStimulus("t5_load_en", 0, 1, 1, 1, 0, 2'd0, 4'd6, 4'd9);
        checkCount("t5_load_only", 4'd6);

        // limit 0: every enabled step is terminal, both directions
        applyStimulus("lim0_up", 0, 0, 1, 1, 0, 2'd0, 4'd0, 4'd0);
        applyStimulus("lim0_up2", 0, 0, 1, 1, 0, 2'd0, 4'd0, 4'd0);
        applyStimulus("lim0_dn", 0, 0, 1, 0, 0, 2'd0, 4'd0, 4'd0);
        checkFlag("lim0_tc", tc, 1'b1);

        // 6: asynchronous reset mid-count
        applyStimulus("t6_clr", 1, 0, 0, 1, 0, 2'd0, 4'd0, 4'd12);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t6_cnt", 0, 0, 1, 1, 0, 2'd0, 4'd0, 4'd12);
        end
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("t6_async");
        checkCount("t6_async_val", 4'd7);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t6_released");
        applyStimulus("t6_resume", 0, 0, 1, 1, 0, 2'd0, 4'd0, 4'd12);
        checkCount("t6_resume_cnt", 4'd8);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bit c;
            bit ld;
            bit e;
            bit oc;
            logic [1:0] m;
            logic [W-1:0] lim;
            c = ($urandom_range(0, 19) == 0);
            ld = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            oc = ($urandom_range(0, 7) == 0);
            m = (i % 40 < 10) ? 2'd2 : 2'($urandom_range(0, 3));
            lim = (i % 25 == 0) ? 4'($urandom_range(0, 15)) : limit;
            applyStimulus("rand", c, ld, e, 1'($urandom_range(0, 1)), oc, m,
                          4'($urandom_range(0, 15)), lim);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised, runtime-programmable successor to the plain free-running enable counter.
- Supports up/down counting, a programmable terminal value, and three terminal behaviours: wrap, saturate and one-shot.
- Provides synchronous load/clear, a registered terminal-count pulse and a sticky overflow flag.
- Used in the FIR datapath for tap-index sequencing, circular sample-buffer pointers and sample-rate strobes.

Parameters:
- WIDTH, 8, counter width in bits; count range is 0..2^WIDTH-1.
- RESET_VAL, 0, value of count after rst; must be < 2^WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to 0.
- en  input  1  count enable.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load.
- dir  input  1  1 = up, 0 = down.
- mode  input  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap).
- limit  input  WIDTH  terminal value for up-count; count range is 0..limit.
- ovf_clr  input  1  clears ovf.
- count  output  WIDTH  current count, registered.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky wrap-event flag.
- running  output  1  0 once a one-shot has completed.

Behaviour:
- Reset (async, rst=1): count=RESET_VAL, tc=0, ovf=0, running=1, state=RUN.
- Update priority per clock edge: clr > load > en.
  - clr: count=0, ovf=0, state=RUN, tc=0.
  - load: count=load_val, state=RUN, tc=0; en is ignored in the same cycle.
- Terminal value: limit when dir=1; 0 when dir=0.
- "At terminal": dir=1 and count>=limit, or dir=0 and count==0.
- Enabled step (en=1, state=RUN, no clr/load):
  - Not at terminal, dir=1: count+1.
  - Not at terminal, dir=0 and count<=limit: count-1.
  - dir=0 and count>limit: count=limit (clamp), all modes; this is not a terminal event.
  - At terminal, wrap: up gives count=0, down gives count=limit; ovf set.
  - At terminal, saturate: up gives count=limit (clamped, even if previously above), down holds 0; ovf unchanged.
  - At terminal, one-shot: count clamped as in saturate; state goes RUN->DONE.
- tc=1 for exactly one cycle following any enabled step taken at terminal, in every mode; otherwise tc=0.
- State machine: RUN, DONE.
  - RUN->DONE only on an enabled step at terminal in mode 2.
  - DONE->RUN on clr, on load, or when mode!=2 is sampled.
  - In DONE: en is ignored, count holds, tc=0.
  - running = (state==RUN).
- limit=0: up-count is permanently at terminal. Wrap gives count=0 with tc every enabled cycle; the same holds for down-count.
- ovf:
  - Set on a wrap event.
  - Cleared by ovf_clr or clr.
  - Set wins over a simultaneous ovf_clr.
- Changes to limit, dir or mode take effect on the next edge; no pipeline. Arithmetic is modulo 2^WIDTH, but the terminal checks prevent natural overflow.
- en=0: count, state and ovf hold; tc=0 next cycle.
- rst asserted mid-operation: immediate return to reset values regardless of the clock.

Decomposition:
- counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_t {CNT_WRAP, CNT_SAT, CNT_ONESHOT, CNT_RSVD}.
  - typedef enum logic {ST_RUN, ST_DONE} cnt_state_t.
- No sub-module. Next-count logic, the FSM and the ovf register are all inline in mod_counter.

Test Plan:
1. WIDTH=4, limit=5, mode=wrap, dir=1, en=1 for 14 cycles -> count 0..5,0..5,0,1; tc high the cycle after each 5->0 step; ovf=1 after the first wrap; ovf_clr pulse -> ovf=0.
2. mode=saturate, dir=0, load_val=3 then en for 6 cycles -> count 3,2,1,0,0,0; tc pulses after each enabled cycle at 0; ovf stays 0.
3. mode=one-shot, dir=1, limit=2, en held -> count 0,1,2,2; running drops after the 2nd-at-terminal step; further en leaves count=2 and tc=0; load_val=0 -> running=1 and counting resumes.
4. count=9, limit reprogrammed to 4: dir=1 wrap step -> count=0 with tc; dir=0 step -> count=4 clamped with no tc.
5. clr, load and en asserted together -> count=0, ovf=0; load and en without clr -> count=load_val with no increment.
6. rst asserted asynchronously mid-count with RESET_VAL=7 -> count=7, tc=0, ovf=0, running=1 before the next edge; counting resumes from 7 after rst is released.
